// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the countdown controller and its BCD digit counter.
package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int         MS_PER_SEC = 1000;
  localparam int         MS_CNT_W   = 10;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Out-of-range BCD input digits saturate to 9 rather than wrapping.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_ctrl_bcd_down_counter.sv
// Two-digit BCD seconds register: clamped parallel load, one-second decrement with tens borrow.
module bcd_down_counter
  import countdown_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  input  logic       i_dec,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_zero,
  output logic       o_one
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_zero;

  assign w_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

  // Load wins over decrement; the value never decrements below 00.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_load) begin
      r_tens <= bcd_clamp(i_tens);
      r_ones <= bcd_clamp(i_ones);
    end else if (i_dec && !w_zero) begin
      if (r_ones == 4'd0) begin
        r_ones <= BCD_MAX;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;
  assign o_zero = w_zero;
  assign o_one  = (r_tens == 4'd0) && (r_ones == 4'd1);

endmodule

// File: rtl/countdown_ctrl.sv
// Seconds countdown driven by 1 ms ticks; IDLE/RUN/PAUSE FSM with registered outputs.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last start value at 00 instead of stopping.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       pause,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       ms_tick,
  output logic       timer_enable,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done_nxt;
  logic                r_done;
  logic                r_timer_en;
  logic                r_busy;
  logic [MS_CNT_W-1:0] r_ms_cnt;

  logic                w_start_idle;
  logic                w_load_zero;
  logic                w_tick_run;
  logic                w_sec_wrap;
  logic                w_boundary;
  logic                w_bcd_load;
  logic [3:0]          w_bcd_tens;
  logic [3:0]          w_bcd_ones;
  logic                w_bcd_dec;
  logic                w_bcd_zero;
  logic                w_bcd_one;

  assign w_start_idle = (r_state == ST_IDLE) && start;
  assign w_load_zero  = (bcd_clamp(load_tens) == 4'd0) && (bcd_clamp(load_ones) == 4'd0);
  // A cancel in the same cycle swallows the tick.
  assign w_tick_run   = (r_state == ST_RUN) && ms_tick && !cancel;
  assign w_sec_wrap   = w_tick_run && (r_ms_cnt == MS_CNT_W'(MS_PER_SEC - 1));
  assign w_boundary   = w_sec_wrap && w_bcd_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [3:0] r_reload_tens;
  logic [3:0] r_reload_ones;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reload_tens <= 4'd0;
      r_reload_ones <= 4'd0;
    end else if (w_start_idle) begin
      r_reload_tens <= bcd_clamp(load_tens);
      r_reload_ones <= bcd_clamp(load_ones);
    end
  end

  assign w_bcd_load = w_start_idle || w_boundary;
  assign w_bcd_tens = w_boundary ? r_reload_tens : load_tens;
  assign w_bcd_ones = w_boundary ? r_reload_ones : load_ones;
`else
  assign w_bcd_load = w_start_idle;
  assign w_bcd_tens = load_tens;
  assign w_bcd_ones = load_ones;
`endif

  assign w_bcd_dec = w_sec_wrap && !w_bcd_zero;

  bcd_down_counter u_bcd (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_bcd_load),
    .i_tens (w_bcd_tens),
    .i_ones (w_bcd_ones),
    .i_dec  (w_bcd_dec),
    .o_tens (secs_tens),
    .o_ones (secs_ones),
    .o_zero (w_bcd_zero),
    .o_one  (w_bcd_one)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ms_cnt <= '0;
    end else if (w_start_idle) begin
      r_ms_cnt <= '0;
    end else if (w_tick_run) begin
      r_ms_cnt <= w_sec_wrap ? '0 : r_ms_cnt + MS_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_load_zero) w_done_nxt  = 1'b1;
          else             w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_boundary) begin
          w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_state_nxt = pause ? ST_PAUSE : ST_RUN;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else if (pause) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (cancel)      w_state_nxt = ST_IDLE;
        else if (!pause) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are derived from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_timer_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_timer_en <= (w_state_nxt == ST_RUN);
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign timer_enable = r_timer_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: directed vectors, done-pulse and snapshot queues.
module tb_countdown_ctrl;

  localparam int W = 12;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       ms_tick;
  logic       timer_enable;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  logic         snap_req;
  logic [W-1:0] snap_q[$];
  logic [W-1:0] done_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  string        mon_name;

  countdown_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cancel       (cancel),
    .pause        (pause),
    .load_tens    (load_tens),
    .load_ones    (load_ones),
    .ms_tick      (ms_tick),
    .timer_enable (timer_enable),
    .secs_tens    (secs_tens),
    .secs_ones    (secs_ones),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input logic [3:0] t, input logic [3:0] o,
                                        input logic b, input logic te, input logic [1:0] st);
    return {t, o, b, te, st};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    mon_act = {secs_tens, secs_ones, busy, timer_enable, dbg_state};
    if (done) begin
      n_checks++;
      if (done_q.size() == 0) begin
        $display("FAIL unexpected_done act={t,o,busy,ten,st}=%h req=no done", mon_act);
      end else begin
        mon_exp = done_q.pop_front();
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL done_state act=%h req=%h", mon_act, mon_exp);
      end
    end
    if (snap_req) begin
      n_checks++;
      mon_exp  = snap_q.pop_front();
      mon_name = name_q.pop_front();
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL %s act={t,o,busy,ten,st}=%h req=%h", mon_name, mon_act, mon_exp);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string nm, input logic [W-1:0] e);
    snap_q.push_back(e);
    name_q.push_back(nm);
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic start_load(input logic [3:0] t, input logic [3:0] o);
    load_tens = t;
    load_ones = o;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic ticks(input int n);
    ms_tick = 1'b1;
    repeat (n) cyc();
    ms_tick = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0; ms_tick = 1'b0; snap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap("reset", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    rst = 1'b1;
    cyc();

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // 02 counts to 00 and stops
    start_load(4'd0, 4'd2);
    snap("t02_loaded", pack(4'd0, 4'd2, 1'b1, 1'b1, S_RUN));
    ticks(1000);
    snap("t02_at_1000", pack(4'd0, 4'd1, 1'b1, 1'b1, S_RUN));
    done_q.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    ticks(1000);
    snap("t02_at_2000", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    snap("t02_after", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
`endif

    // tens borrow 10 -> 09
    start_load(4'd1, 4'd0);
    ticks(1000);
    snap("t10_borrow", pack(4'd0, 4'd9, 1'b1, 1'b1, S_RUN));
    pulse_cancel();
    snap("t10_cancel", pack(4'd0, 4'd9, 1'b0, 1'b0, S_IDLE));

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // pause holds the count; the tick in the pausing cycle still counts
    start_load(4'd0, 4'd5);
    ticks(1500);
    pause = 1'b1;
    ticks(300);
    snap("t05_paused", pack(4'd0, 4'd4, 1'b1, 1'b0, S_PAUSE));
    pause = 1'b0;
    cyc();
    snap("t05_resumed", pack(4'd0, 4'd4, 1'b1, 1'b1, S_RUN));
    ticks(3498);
    snap("t05_tick_4999", pack(4'd0, 4'd1, 1'b1, 1'b1, S_RUN));
    done_q.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    ticks(1);
    snap("t05_tick_5000", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    ticks(1);
    snap("t05_idle_tick", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
`endif

    // cancel beats start/pause/tick; IDLE holds digits and ignores ticks
    start_load(4'd0, 4'd3);
    ticks(1200);
    cancel = 1'b1; start = 1'b1; pause = 1'b1; ms_tick = 1'b1;
    cyc();
    cancel = 1'b0; start = 1'b0; pause = 1'b0; ms_tick = 1'b0;
    snap("t03_cancel", pack(4'd0, 4'd2, 1'b0, 1'b0, S_IDLE));
    ticks(5);
    snap("t03_idle_hold", pack(4'd0, 4'd2, 1'b0, 1'b0, S_IDLE));

    // reset mid-run wins over start and tick
    start_load(4'd0, 4'd3);
    ticks(10);
    rst = 1'b0; start = 1'b1; ms_tick = 1'b1;
    cyc();
    rst = 1'b1; start = 1'b0; ms_tick = 1'b0;
    snap("midrun_reset", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));

    // zero load: done one cycle later, never runs
    done_q.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    start_load(4'd0, 4'd0);
    snap("zero_start", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));
    snap("zero_after", pack(4'd0, 4'd0, 1'b0, 1'b0, S_IDLE));

    // clamp, start ignored in RUN, decrement from 99
    start_load(4'd12, 4'd15);
    snap("clamp_99", pack(4'd9, 4'd9, 1'b1, 1'b1, S_RUN));
    start_load(4'd3, 4'd4);
    snap("start_in_run", pack(4'd9, 4'd9, 1'b1, 1'b1, S_RUN));
    ticks(1000);
    snap("dec_99_98", pack(4'd9, 4'd8, 1'b1, 1'b1, S_RUN));
    pulse_cancel();
    start_load(4'd5, 4'd11);
    snap("clamp_59", pack(4'd5, 4'd9, 1'b1, 1'b1, S_RUN));
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    pulse_cancel();
    snap("pause_cancel", pack(4'd5, 4'd9, 1'b0, 1'b0, S_IDLE));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // 01 reloads three times and keeps running
    start_load(4'd0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      done_q.push_back(pack(4'd0, 4'd1, 1'b1, 1'b1, S_RUN));
      ticks(1000);
      snap("reload_01", pack(4'd0, 4'd1, 1'b1, 1'b1, S_RUN));
    end
    pulse_cancel();
    snap("reload_cancel", pack(4'd0, 4'd1, 1'b0, 1'b0, S_IDLE));
`endif

    repeat (3) cyc();
    if (done_q.size() != 0) begin
      n_checks++;
      $display("FAIL done_missing act=%0d pulses outstanding req=0", done_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port start  input  1  one-cycle request to load and run the countdown.
REQ-004 SHALL have port cancel  input  1  abort the countdown; return to IDLE with no done.
REQ-005 SHALL have port pause  input  1  level; high holds the count, low resumes.
REQ-006 SHALL have port load_tens  input  4  BCD tens digit of the start value, in seconds.
REQ-007 SHALL have port load_ones  input  4  BCD ones digit of the start value, in seconds.
REQ-008 SHALL have port ms_tick  input  1  one-cycle pulse from the 1 ms LFSR timer (its timeout output).
REQ-009 SHALL have port timer_enable  output  1  registered enable to the 1 ms LFSR timer.
REQ-010 SHALL have port secs_tens  output  4  BCD tens digit remaining.
REQ-011 SHALL have port secs_ones  output  4  BCD ones digit remaining.
REQ-012 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the count reaches 00.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, PAUSE; all outputs SHALL be registered.
REQ-015 IDLE + start: digits loaded (any digit >9 clamped to 9); ms counter cleared; next state RUN; timer_enable high from the following cycle.
REQ-016 start with a clamped load value of 00: stay in IDLE; done pulses for one cycle, in the cycle after start; timer_enable stays low.
REQ-017 start while in RUN or PAUSE: ignored.
REQ-018 RUN: each ms_tick increments a 10-bit ms counter 0..999; at 999 + ms_tick the counter wraps to 0 and the BCD value decrements by one second.
REQ-019 BCD decrement: if ones==0, ones becomes 9 and tens decrements; otherwise ones decrements.
REQ-020 Decrement edge from 01 to 00: digits become 00, done=1 for exactly one cycle, timer_enable=0, state returns to IDLE (see REQ-029 for the alternative).
REQ-021 ms_tick while not in RUN: ignored.
REQ-022 RUN + pause: next state PAUSE, timer_enable=0; an ms_tick sampled in that same cycle is still counted.
REQ-023 PAUSE + pause low: next state RUN, timer_enable=1; the ms counter and digits are preserved.
REQ-024 cancel in RUN or PAUSE: next state IDLE, timer_enable=0, digits unchanged, no done; cancel takes priority over start, pause and ms_tick in the same cycle.
REQ-025 In IDLE the digits hold their last value until the next start.

Reset
REQ-026 rst low at any clock edge, including mid-countdown: state=IDLE, ms counter=0, secs_tens=0, secs_ones=0, timer_enable=0, busy=0, done=0.
REQ-027 Reset SHALL take priority over all other inputs.

Configuration
REQ-028 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select the behaviour at the 00 boundary.
REQ-029 With the macro defined: at 01 to 00, done pulses, the last loaded value is reloaded, the FSM stays in RUN and timer_enable stays high.
REQ-030 Without the macro: behaviour is exactly REQ-020, and the reload register SHALL NOT be instantiated.

Structure
REQ-031 A shared package SHALL hold the state typedef, MS_PER_SEC=1000, MS_CNT_W=10 and BCD_MAX=9.
REQ-032 BCD digit-pair storage, load, clamp and decrement SHALL live in sub-module bcd_down_counter, with outputs for the digits and a zero flag.

Verification
REQ-033 Load 02, start, 2000 ms_tick pulses -> digits 01 after tick 1000, 00 after tick 2000; done high for 1 cycle; timer_enable low and busy low afterwards.
REQ-034 Load 10, start, 1000 ticks -> digits 09, showing the tens borrow.
REQ-035 Load 05, start, 1500 ticks, pause for 300 cycles while also driving ms_tick, release pause, 3500 more ticks -> digits 04 during the pause; done after the 5000th counted tick only.
REQ-036 Load 03, cancel after 1200 ticks -> IDLE, digits 02, done never asserted; then reset mid-run -> all outputs 0.
REQ-037 Load 00 with start -> done pulse one cycle later and timer_enable never high; load tens=12, ones=15 -> digits start at 99.
REQ-038 With COUNTDOWN_AUTO_RELOAD_EN defined, load 01, 3000 ticks -> done pulses 3 times, busy stays high and digits read 01 after each reload.
